// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit and data memory.
// A single request/acknowledge transaction is carried per access.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I data-memory port: one bus transaction per load/store,
// stalling the core until the access completes or errors out.
module load_store_unit #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic                     store_i,
  input  logic [2:0]               fun3_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              store_data_i,
  output logic                     stall_o,
  output logic [31:0]              load_data_o,
  output logic                     lsu_done_o,
  output logic                     lsu_err_o,
  load_store_unit_if.master        bus
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  fun3_q, fun3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_data_q, load_data_d;

  logic        start;
  logic        fun3_ok;
  logic        aligned;
  logic        legal;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rdata_ext;

  // Start decode and legality checks
  always_comb begin
    start   = load_i | store_i;
    fun3_ok = 1'b0;
    case (fun3_i)
      3'b000, 3'b001, 3'b010: fun3_ok = 1'b1;
      3'b100, 3'b101:         fun3_ok = load_i;
      default:                fun3_ok = 1'b0;
    endcase
    aligned = 1'b1;
    case (fun3_i[1:0])
      2'b01:   aligned = ~addr_i[0];
      2'b10:   aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    legal = ~(load_i & store_i) & fun3_ok & aligned;
  end

  // Store lane replication and byte strobes
  always_comb begin
    st_wdata = store_data_i;
    st_wstrb = 4'b1111;
    case (fun3_i[1:0])
      2'b00: begin
        st_wdata = {4{store_data_i[7:0]}};
        st_wstrb = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data_i[15:0]}};
        st_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = store_data_i;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction uses the captured offset/size, not the live inputs
  always_comb begin
    rbyte     = bus.rdata[{off_q, 3'b000} +: 8];
    rhalf     = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    rdata_ext = bus.rdata;
    case (fun3_q)
      3'b000:  rdata_ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  rdata_ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  rdata_ext = {24'h000000, rbyte};
      3'b101:  rdata_ext = {16'h0000, rhalf};
      default: rdata_ext = bus.rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    fun3_d      = fun3_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (legal) begin
            state_d = StReq;
            cnt_d   = '0;
            err_d   = 1'b0;
            we_d    = store_i;
            addr_d  = {addr_i[31:2], 2'b00};
            wdata_d = store_i ? st_wdata : '0;
            wstrb_d = store_i ? st_wstrb : 4'b0000;
            fun3_d  = fun3_i;
            off_d   = addr_i[1:0];
          end else begin
            state_d     = StDone;
            err_d       = 1'b1;
            load_data_d = '0;
          end
        end
      end
      StReq: begin
        // An ack in the final allowed cycle wins over the timeout
        if (bus.ack) begin
          state_d = StDone;
          err_d   = 1'b0;
          if (!we_q) load_data_d = rdata_ext;
        end else if ((TimeoutCycles != 0) && (cnt_q == TimeoutCycles - 1)) begin
          state_d     = StDone;
          err_d       = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      fun3_q      <= '0;
      off_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      fun3_q      <= fun3_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
    end
  end

  // Reset gates stall so it drops at once even with Load/Store still high
  assign stall_o     = rst_ni & (((state_q == StIdle) & start) | (state_q == StReq));
  assign lsu_done_o  = (state_q == StDone);
  assign lsu_err_o   = (state_q == StDone) & err_q;
  assign load_data_o = load_data_q;
  assign bus.req     = (state_q == StReq);
  assign bus.we      = we_q;
  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit against a size/offset
// arithmetic reference model, with a short timeout to reach the abort path.
module tb_load_store_unit;
  localparam int unsigned To = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  fun3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  load_store_unit_if bus ();

  load_store_unit #(.TimeoutCycles(To)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (load),
    .store_i     (store),
    .fun3_i      (fun3),
    .addr_i      (addr),
    .store_data_i(sdata),
    .stall_o     (stall),
    .load_data_o (load_data),
    .lsu_done_o  (done),
    .lsu_err_o   (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ref_size(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    return 32'd1 << s;
  endfunction

  function automatic bit ref_legal(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a);
    int unsigned size;
    size = ref_size(f3);
    if (ld && st) return 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (st && f3 > 3'd2) return 1'b0;
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned size;
    logic [31:0] v;
    size = ref_size(f3);
    if (size == 4) return rd;
    v = rd >> (8 * (a % 4));
    v = v & ((32'd1 << (8 * size)) - 1);
    if (f3 < 3'd4 && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int unsigned size;
    logic [31:0] b;
    logic [31:0] h;
    size = ref_size(f3);
    b = sd & 32'hFF;
    h = sd & 32'hFFFF;
    if (size == 1) return b * 32'h01010101;
    if (size == 2) return h * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    size = ref_size(f3);
    return ((32'd1 << size) - 1) << (a % 4);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // ack_dly: REQ-cycle index (0 = first) on which ack is given; negative = never.
  task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int ack_dly, input logic [31:0] rd);
    bit          legal;
    bit          exp_err;
    int          exp_req;
    int          stall_n;
    int          req_n;
    bit          done_seen;
    logic [31:0] exp_ld;
    legal = ref_legal(ld, st, f3, a);
    if (!legal) begin
      exp_req = 0;
      exp_err = 1'b1;
    end else if (ack_dly < 0 || ack_dly >= int'(To)) begin
      exp_req = To;
      exp_err = 1'b1;
    end else begin
      exp_req = ack_dly + 1;
      exp_err = 1'b0;
    end
    exp_ld = exp_err ? 32'h0 : ref_load(f3, a, rd);
    load = ld; store = st; fun3 = f3; addr = a; sdata = sd;
    bus.ack = 1'b0;
    stall_n = 0; req_n = 0; done_seen = 1'b0;
    for (int cyc = 0; cyc < int'(To) + 6 && !done_seen; cyc++) begin
      #1;
      if (stall) stall_n++;
      if (bus.req) begin
        check("bus_we", {31'd0, bus.we}, {31'd0, st});
        check("bus_addr", bus.addr, a & 32'hFFFF_FFFC);
        check("bus_wstrb", {28'd0, bus.wstrb}, st ? ref_wstrb(f3, a) : 32'd0);
        if (st) check("bus_wdata", bus.wdata, ref_wdata(f3, sd));
        bus.ack   = (req_n == ack_dly);
        bus.rdata = bus.ack ? rd : $urandom;
        req_n++;
      end else begin
        bus.ack = 1'b0;
      end
      if (done) begin
        done_seen = 1'b1;
        check("lsu_err", {31'd0, err}, {31'd0, exp_err});
        check("done_stall", {31'd0, stall}, 32'd0);
        check("done_req", {31'd0, bus.req}, 32'd0);
        if (ld || exp_err) check("load_data", load_data, exp_ld);
        load = 1'b0;
        store = 1'b0;
      end
      @(negedge clk);
    end
    check("done_seen", {31'd0, done_seen}, 32'd1);
    check("stall_cycles", stall_n, exp_req + 1);
    check("req_cycles", req_n, exp_req);
    #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    load = 1'b0;
    store = 1'b0;
    bus.ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.ack   = 1'b0;
    bus.rdata = '0;
    #3;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_req", {31'd0, bus.req}, 32'd0);
    check("rst_we", {31'd0, bus.we}, 32'd0);
    check("rst_addr", bus.addr, 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_wstrb", {28'd0, bus.wstrb}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0);
    access(1'b0, 1'b1, 3'b000, 32'h103, 32'h123456A5, 0, 32'h0);
    access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 0, 32'h0);
    access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0, 32'h0080FF11);
    check("lb_literal", load_data, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0, 32'h0080FF11);
    check("lbu_literal", load_data, 32'h00000080);
    access(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 0, 32'h0080FF11);
    check("lh_literal", load_data, 32'hFFFFFF11);
    access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h0080FF11);
    check("lhu_literal", load_data, 32'h00000080);
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h0080FF11);
    check("lw_literal", load_data, 32'h0080FF11);
    access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h12345678);
    access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h12345678);
    access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'h12345678);
    access(1'b0, 1'b1, 3'b100, 32'h100, 32'h55, 0, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, -1, 32'hCAFEF00D);
    access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 3, 32'hCAFEF00D);

    // Asynchronous reset on the second REQ cycle of a load
    load = 1'b1; store = 1'b0; fun3 = 3'b010; addr = 32'h180; bus.ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_req", {31'd0, bus.req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, bus.req}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_load_data", load_data, 32'd0);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0, 32'h89ABCDEF);

    for (int i = 0; i < 80; i++) begin
      bit          ld;
      bit          st;
      int unsigned kind;
      kind = $urandom_range(0, 9);
      ld = (kind == 0) || (kind >= 5);
      st = (kind <= 4);
      access(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, 5)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory port for the RV32I core, sitting on the other end of the decoder's Load/Store/fun3 control outputs. It turns a decoded load or store into a single request/acknowledge transaction on the data bus and stalls the core until that transaction finishes. For stores it generates byte-lane strobes and replicated write data. For loads it returns sign- or zero-extended data to the register-file writeback path.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of REQ cycles without acknowledge before the access is aborted with an error. A value of 0 disables the timeout.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Load  in  1  current instruction is a load.
- Store  in  1  current instruction is a store.
- fun3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  effective byte address (ALU result).
- store_data  in  32  rs2 value.
- stall  out  1  hold the PC and instruction; the core must keep all inputs stable while this is high.
- load_data  out  32  extended load result, registered.
- lsu_done  out  1  one-cycle pulse; the access completes this cycle.
- lsu_err  out  1  one-cycle pulse together with lsu_done; the access failed.
- bus_req  out  1  bus request.
- bus_we  out  1  1 means write.
- bus_addr  out  32  word-aligned address: {addr[31:2],2'b00}.
- bus_wdata  out  32  write data.
- bus_wstrb  out  4  byte-lane enables; 0000 on reads.
- bus_ack  in  1  request accepted and completed this cycle.
- bus_rdata  in  32  read data; valid only in the bus_ack cycle.

## Operation
- States: IDLE, REQ, DONE.
- A start occurs in IDLE when Load|Store is high.
- IDLE to REQ on a legal start. Bus outputs are registered from addr, fun3, store_data and Load/Store, and are held constant throughout REQ.
- IDLE to DONE with the error flag set, and no bus activity, on any illegal start:
  - Load and Store both high.
  - Undefined fun3: a load with 011, 110 or 111; a store with anything other than 000–010.
  - Misalignment: h/hu/sh with addr[0]=1, or w/sw with addr[1:0]≠00.
- REQ to DONE when bus_ack is sampled high.
- REQ to DONE with the error flag set when the timeout counter reaches TIMEOUT_CYCLES without bus_ack.
- DONE to IDLE unconditionally.
- Store lanes, with a = addr[1:0]:
  - sb: wdata = {4{store_data[7:0]}}, wstrb = 0001<<a.
  - sh: wdata = {2{store_data[15:0]}}, wstrb = 0011 if addr[1]=0, else 1100.
  - sw: wdata = store_data, wstrb = 1111.
- Load extraction:
  - lb/lbu select byte a; lh/lhu select halfword addr[1]; lw takes the full word.
  - b/h are sign-extended; bu/hu are zero-extended.
  - The result is captured into load_data on the bus_ack cycle.
- On error, load_data is written to 0x00000000.
- load_data holds its value until the next lsu_done.

## Timing
- Reset (asynchronous, active-low): state is IDLE, the timeout counter is 0, and the following are all 0: stall, lsu_done, lsu_err, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, load_data.
- stall = (IDLE & start) | REQ, and is combinational from Load/Store in IDLE. In DONE, stall=0, so the instruction retires and no new start is evaluated until IDLE.
- bus_req = 1 exactly while in REQ. The bus may assert bus_ack in the first REQ cycle.
- Latency:
  - Minimum legal access: stall is high for 2 cycles (IDLE, REQ with ack), followed by the DONE cycle.
  - In general: stall-high cycles = 1 + REQ cycles.
  - Illegal access: stall is high for exactly 1 cycle, then DONE.
- lsu_done and lsu_err are asserted only in DONE. load_data is valid from the DONE cycle onward.
- Timeout counter:
  - Cleared on entry to REQ and incremented each REQ cycle without ack.
  - The abort occurs in the cycle in which count = TIMEOUT_CYCLES−1 with no ack, so bus_req stays high for exactly TIMEOUT_CYCLES cycles.
  - An ack in that same cycle takes priority and produces no error.
- Reset mid-transaction: bus_req and stall drop immediately (asynchronously). There is no retry and no lsu_done.

## Test plan
- sw, addr=0x100, store_data=0xDEADBEEF, ack on the 3rd REQ cycle -> bus_we=1, bus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; stall high 4 cycles; one lsu_done, lsu_err=0.
- sb, addr=0x103, store_data=0x123456A5; then sh, addr=0x102, store_data=0x0000BEEF; each with immediate ack -> sb gives bus_addr=0x100, wdata=0xA5A5A5A5, wstrb=1000; sh gives wdata=0xBEEFBEEF, wstrb=1100.
- Loads with bus_rdata=0x0080FF11:
  - lb @0x102 -> 0xFFFFFF80
  - lbu @0x102 -> 0x00000080
  - lh @0x100 -> 0xFFFFFF11
  - lhu @0x102 -> 0x00000080
  - lw @0x100 -> 0x0080FF11
- lw @0x102 and lh @0x101 -> bus_req never asserts; stall high 1 cycle; lsu_done=lsu_err=1 for one cycle; load_data=0x00000000.
- TIMEOUT_CYCLES=4, bus_ack held 0 -> bus_req high exactly 4 cycles, then DONE with lsu_err=1. A repeat with ack arriving on the 4th cycle -> no error.
- rst asserted on the 2nd REQ cycle of a load -> bus_req and stall drop immediately; after release, state is IDLE and a new lw @0x200 with immediate ack completes normally.
